// File: rtl/gcm_ingress_sequencer_pkg.sv
// Shared types and constants for the GCM ingress sequencer and its FIFO.
// Block vectors are declared [0:BLK_W-1] so that bit 0 is the MSB.
package gcm_pkg;

  localparam int BLK_W = 128;
  localparam int IV_W  = 96;
  localparam int KEY_W = 128;
  localparam int LEN_W = 64;

  typedef struct packed {
    logic [KEY_W-1:0] key;
    logic [IV_W-1:0]  iv;
    logic [LEN_W-1:0] aad_bits;
    logic [LEN_W-1:0] pt_bits;
  } gcm_desc_t;

  typedef enum logic [1:0] {IDLE, CHECK, FILL, ISSUE} seq_state_t;

  // Ceiling of len/128 over the full 64-bit length; the result cannot overflow.
  function automatic logic [LEN_W-1:0] blocks_of(input logic [LEN_W-1:0] len);
    return (len >> 7) + {{(LEN_W-1){1'b0}}, |len[6:0]};
  endfunction

endpackage

// File: rtl/gcm_ingress_sequencer_if.sv
// Ingress bundle: message descriptor channel plus the in-order data block channel.
interface gcm_ingress_if;
  import gcm_pkg::*;

  logic             desc_valid;
  logic             desc_ready;
  logic [KEY_W-1:0] desc_key;
  logic [IV_W-1:0]  desc_iv;
  logic [LEN_W-1:0] desc_aad_bits;
  logic [LEN_W-1:0] desc_pt_bits;
  logic             blk_valid;
  logic             blk_ready;
  logic [0:BLK_W-1] blk_data;

  modport master (
    output desc_valid, desc_key, desc_iv, desc_aad_bits, desc_pt_bits,
    output blk_valid, blk_data,
    input  desc_ready, blk_ready
  );

  modport slave (
    input  desc_valid, desc_key, desc_iv, desc_aad_bits, desc_pt_bits,
    input  blk_valid, blk_data,
    output desc_ready, blk_ready
  );

endinterface

// File: rtl/gcm_ingress_sequencer_fifo.sv
// Block FIFO with a combinational head (rd_data shows the oldest entry) and an occupancy count.
module gcm_blk_fifo
  import gcm_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           push,
  input  logic [0:BLK_W-1]               wr_data,
  input  logic                           pop,
  output logic [0:BLK_W-1]               rd_data,
  output logic [$clog2(DEPTH+1)-1:0]     count,
  output logic                           full
);

  localparam int CNT_W = $clog2(DEPTH+1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [0:BLK_W-1] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH-1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full    = (count == CNT_W'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && (count != '0);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; only pointers and count define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/gcm_ingress_sequencer.sv
// Buffers one whole GCM message (AAD blocks then PT blocks) and replays it to the
// gcm_aes core gap-free, one block per cycle, with instance flags, sizes and tail masking.
module gcm_ingress_sequencer
  import gcm_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  gcm_ingress_if.slave      ing,
  output logic              o_valid,
  output logic              o_new_instance,
  output logic              o_pt_instance,
  output logic [KEY_W-1:0]  o_cipher_key,
  output logic [IV_W-1:0]   o_iv,
  output logic [0:BLK_W-1]  o_aad,
  output logic [0:BLK_W-1]  o_plain_text,
  output logic [LEN_W-1:0]  o_aad_size,
  output logic [LEN_W-1:0]  o_plain_text_size,
  output logic              o_busy,
  output logic              o_err
);

  localparam int CNT_W = $clog2(DEPTH+1);

  seq_state_t       state;
  gcm_desc_t        desc_q;
  logic [CNT_W-1:0] na_q;
  logic [CNT_W-1:0] n_q;
  logic [CNT_W-1:0] rcv_q;
  logic [CNT_W-1:0] idx_q;

  logic [LEN_W-1:0] na_w;
  logic [LEN_W-1:0] np_w;
  logic [LEN_W:0]   n_w;
  logic             too_big;

  logic [0:BLK_W-1] fifo_head;
  logic [CNT_W-1:0] fifo_count;
  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_push;
  logic             fifo_pop;

  logic             blk_hs;
  logic             last_hs;
  logic [CNT_W-1:0] emit_idx;
  logic [0:BLK_W-1] emit_raw;
  logic [0:BLK_W-1] emit_blk;
  logic             emit_is_pt;

  // Keep bits [0:rem-1] of a block and clear the rest; rem is never 0 here.
  function automatic logic [0:BLK_W-1] tail_mask(input logic [0:BLK_W-1] d,
                                                 input logic [6:0]       rem);
    logic [0:BLK_W-1] ones;
    ones = '1;
    return d & ~(ones >> rem);
  endfunction

  assign ing.desc_ready = (state == IDLE);
  assign ing.blk_ready  = (state == FILL) && (rcv_q < n_q) && !fifo_full;

  assign blk_hs     = ing.blk_valid && ing.blk_ready;
  assign last_hs    = blk_hs && ((rcv_q + CNT_W'(1)) == n_q);
  assign fifo_empty = (fifo_count == '0);

  // The final block of a one-block message bypasses the FIFO so that issue starts
  // the cycle right after its handshake; otherwise it queues behind the earlier blocks.
  assign fifo_push = blk_hs && !(last_hs && fifo_empty);
  assign fifo_pop  = (last_hs && !fifo_empty) || ((state == ISSUE) && (idx_q < n_q));

  assign na_w    = blocks_of(desc_q.aad_bits);
  assign np_w    = blocks_of(desc_q.pt_bits);
  assign n_w     = {1'b0, na_w} + {1'b0, np_w};
  assign too_big = (n_w > (LEN_W+1)'(DEPTH));

  always_comb begin
    emit_idx   = (state == ISSUE) ? idx_q : '0;
    emit_raw   = ((state == FILL) && fifo_empty) ? ing.blk_data : fifo_head;
    emit_is_pt = (emit_idx >= na_q);
    emit_blk   = emit_raw;
    if (!emit_is_pt && (emit_idx == na_q - CNT_W'(1)) && (desc_q.aad_bits[6:0] != '0))
      emit_blk = tail_mask(emit_raw, desc_q.aad_bits[6:0]);
    else if (emit_is_pt && (emit_idx == n_q - CNT_W'(1)) && (desc_q.pt_bits[6:0] != '0))
      emit_blk = tail_mask(emit_raw, desc_q.pt_bits[6:0]);
  end

  gcm_blk_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (fifo_push),
    .wr_data (ing.blk_data),
    .pop     (fifo_pop),
    .rd_data (fifo_head),
    .count   (fifo_count),
    .full    (fifo_full)
  );

  always_ff @(posedge clk) begin
    if ((state == IDLE) && ing.desc_valid)
      desc_q <= '{key:      ing.desc_key,
                  iv:       ing.desc_iv,
                  aad_bits: ing.desc_aad_bits,
                  pt_bits:  ing.desc_pt_bits};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= IDLE;
      na_q              <= '0;
      n_q               <= '0;
      rcv_q             <= '0;
      idx_q             <= '0;
      o_valid           <= 1'b0;
      o_new_instance    <= 1'b0;
      o_pt_instance     <= 1'b0;
      o_cipher_key      <= '0;
      o_iv              <= '0;
      o_aad             <= '0;
      o_plain_text      <= '0;
      o_aad_size        <= '0;
      o_plain_text_size <= '0;
      o_busy            <= 1'b0;
      o_err             <= 1'b0;
    end else begin
      o_err <= 1'b0;
      case (state)
        IDLE: begin
          if (ing.desc_valid) begin
            o_busy <= 1'b1;
            state  <= CHECK;
          end
        end

        CHECK: begin
          if (too_big) begin
            o_err  <= 1'b1;
            o_busy <= 1'b0;
            state  <= IDLE;
          end else if (n_w == '0) begin
            // Empty message: issue one all-zero AAD block, which leaves GHASH unchanged.
            na_q              <= CNT_W'(1);
            n_q               <= CNT_W'(1);
            idx_q             <= CNT_W'(1);
            o_valid           <= 1'b1;
            o_new_instance    <= 1'b1;
            o_pt_instance     <= 1'b0;
            o_aad             <= '0;
            o_plain_text      <= '0;
            o_cipher_key      <= desc_q.key;
            o_iv              <= desc_q.iv;
            o_aad_size        <= desc_q.aad_bits;
            o_plain_text_size <= desc_q.pt_bits;
            state             <= ISSUE;
          end else begin
            na_q  <= na_w[CNT_W-1:0];
            n_q   <= n_w[CNT_W-1:0];
            rcv_q <= '0;
            state <= FILL;
          end
        end

        FILL: begin
          if (blk_hs) rcv_q <= rcv_q + CNT_W'(1);
          if (last_hs) begin
            idx_q             <= CNT_W'(1);
            o_valid           <= 1'b1;
            o_new_instance    <= 1'b1;
            o_pt_instance     <= emit_is_pt;
            o_aad             <= emit_is_pt ? '0 : emit_blk;
            o_plain_text      <= emit_is_pt ? emit_blk : '0;
            o_cipher_key      <= desc_q.key;
            o_iv              <= desc_q.iv;
            o_aad_size        <= desc_q.aad_bits;
            o_plain_text_size <= desc_q.pt_bits;
            state             <= ISSUE;
          end
        end

        ISSUE: begin
          if (idx_q < n_q) begin
            idx_q          <= idx_q + CNT_W'(1);
            o_valid        <= 1'b1;
            o_new_instance <= 1'b0;
            o_pt_instance  <= emit_is_pt;
            o_aad          <= emit_is_pt ? '0 : emit_blk;
            o_plain_text   <= emit_is_pt ? emit_blk : '0;
          end else begin
            o_valid           <= 1'b0;
            o_new_instance    <= 1'b0;
            o_pt_instance     <= 1'b0;
            o_cipher_key      <= '0;
            o_iv              <= '0;
            o_aad             <= '0;
            o_plain_text      <= '0;
            o_aad_size        <= '0;
            o_plain_text_size <= '0;
            o_busy            <= 1'b0;
            state             <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
